// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: control frame codes exchanged between
// masters and slaves, and the arbiter state encoding.
// Ports: none (package).
package serial_bus_pkg;

    // Control frame codes carried on the bus control lines.
    typedef enum logic [2:0] {
        CTRL_ABORT    = 3'b100,
        CTRL_CONTINUE = 3'b101,
        CTRL_HOLD     = 3'b110,
        CTRL_START    = 3'b111
    } control_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_HOLD_WAIT,
        ARB_RESUME
    } arb_state_t;

endpackage

// File: rtl/bus_prio_encoder.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
// Ports: vec_i (W-bit vector in), found_o (any bit set), idx_o (lowest set index, 0 when none).
// Purely combinational, no latency, no flow control.
module bus_prio_encoder #(
    parameter int W  = 2,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Fixed-priority bus arbiter (index 0 highest) with single-level preemption via HOLD/CONTINUE frames.
// Ports: clk_i/rst_n_i; req_i, done_i, hold_ack_i per master; grant_o, hold_o, resume_o one-hot;
//        owner_id_o index of the grantee; busy_o high while any grant is set.
// Grant is registered one cycle after request; an all-zero grant cycle always separates owners.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int MASTERS      = 2,
    parameter int M_ID_WIDTH   = $clog2(MASTERS),
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [MASTERS-1:0]    req_i,
    input  logic [MASTERS-1:0]    done_i,
    input  logic [MASTERS-1:0]    hold_ack_i,
    output logic [MASTERS-1:0]    grant_o,
    output logic [MASTERS-1:0]    hold_o,
    output logic [MASTERS-1:0]    resume_o,
    output logic [M_ID_WIDTH-1:0] owner_id_o,
    output logic                  busy_o
);

    localparam int TW = $clog2(HOLD_TIMEOUT);

    arb_state_t              state_q,   state_d;
    logic [MASTERS-1:0]      grant_q,   grant_d;
    logic [MASTERS-1:0]      hold_q,    hold_d;
    logic [MASTERS-1:0]      resume_q,  resume_d;
    logic                    pre_vld_q, pre_vld_d;
    logic [M_ID_WIDTH-1:0]   pre_id_q,  pre_id_d;
    logic [TW-1:0]           timer_q,   timer_d;

    logic                    pick_found;
    logic [M_ID_WIDTH-1:0]   pick_idx;
    logic                    owner_found;
    logic [M_ID_WIDTH-1:0]   owner_id;
    logic                    owner_release;

    function automatic logic [MASTERS-1:0] onehot(input logic [M_ID_WIDTH-1:0] idx);
        onehot = {{(MASTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Highest-priority requester.
    bus_prio_encoder #(.W(MASTERS), .IW(M_ID_WIDTH)) u_pick (
        .vec_i   (req_i),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Owner index decoded from the one-hot grant; found doubles as busy.
    bus_prio_encoder #(.W(MASTERS), .IW(M_ID_WIDTH)) u_owner (
        .vec_i   (grant_q),
        .found_o (owner_found),
        .idx_o   (owner_id)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        resume_d  = '0;
        pre_vld_d = pre_vld_q;
        pre_id_d  = pre_id_q;
        timer_d   = timer_q;

        // done/holdAck are only ever looked at on the owner's bit.
        owner_release = done_i[owner_id] || !req_i[owner_id];

        unique case (state_q)
            ARB_IDLE: begin
                // With a master parked, hand back to it once it is the best
                // (or only) candidate left; the RESUME cycle does the re-grant.
                if (pre_vld_q && (!pick_found || pick_idx == pre_id_q)) begin
                    state_d = ARB_RESUME;
                end else if (pick_found) begin
                    grant_d = onehot(pick_idx);
                    state_d = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                if (owner_release) begin
                    grant_d = '0;
                    state_d = pre_vld_q ? ARB_RESUME : ARB_IDLE;
                end else if (!pre_vld_q && pick_found && pick_idx < owner_id) begin
                    hold_d  = onehot(owner_id);
                    timer_d = '0;
                    state_d = ARB_HOLD_WAIT;
                end
            end

            ARB_HOLD_WAIT: begin
                if (timer_q != {TW{1'b1}}) begin
                    timer_d = timer_q + 1'b1;
                end
                // Release beats ack: an owner that finishes while holding is
                // simply done and must not be resumed later.
                if (owner_release) begin
                    hold_d  = '0;
                    grant_d = '0;
                    state_d = pre_vld_q ? ARB_RESUME : ARB_IDLE;
                end else if (hold_ack_i[owner_id]) begin
                    hold_d    = '0;
                    grant_d   = '0;
                    pre_vld_d = 1'b1;
                    pre_id_d  = owner_id;
                    state_d   = ARB_IDLE;
                end else if (timer_q == TW'(HOLD_TIMEOUT - 1)) begin
                    hold_d  = '0;
                    state_d = ARB_GRANT;
                end
            end

            ARB_RESUME: begin
                pre_vld_d = 1'b0;
                if (req_i[pre_id_q]) begin
                    grant_d  = onehot(pre_id_q);
                    resume_d = onehot(pre_id_q);
                    state_d  = ARB_GRANT;
                end else begin
                    state_d = ARB_IDLE;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            hold_q    <= '0;
            resume_q  <= '0;
            pre_vld_q <= 1'b0;
            pre_id_q  <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            resume_q  <= resume_d;
            pre_vld_q <= pre_vld_d;
            pre_id_q  <= pre_id_d;
            timer_q   <= timer_d;
        end
    end

    assign grant_o    = grant_q;
    assign hold_o     = hold_q;
    assign resume_o   = resume_q;
    assign owner_id_o = owner_id;
    assign busy_o     = owner_found;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter with three masters and an eight-cycle hold timeout.
// An owner/parked-master model tracks the bus and is compared every cycle;
// directed scenarios add literal expectations on key cycles.
module tb_serial_bus_arbiter;

    localparam int M  = 3;
    localparam int TO = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [M-1:0] req   = '0;
    logic [M-1:0] done  = '0;
    logic [M-1:0] ack   = '0;
    logic [M-1:0] grant, hold, resume;
    logic [1:0]   owner_id;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    serial_bus_arbiter #(.MASTERS(M), .HOLD_TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .done_i     (done),
        .hold_ack_i (ack),
        .grant_o    (grant),
        .hold_o     (hold),
        .resume_o   (resume),
        .owner_id_o (owner_id),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- model: who owns the bus, who is parked ----------------
    int m_owner    = -1;  // current grantee, -1 when the bus is free
    int m_stored   = -1;  // master parked by a completed HOLD, -1 when none
    int m_resume   = -1;  // master receiving its CONTINUE pulse this cycle
    int m_hold_age = 0;   // cycles hold has been shown to the owner
    bit m_holding  = 1'b0;
    bit m_wake     = 1'b0; // next free cycle is the hand-back to the parked master

    function automatic int first_req(input logic [M-1:0] r);
        for (int i = 0; i < M; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [M-1:0] bit_of(input int i);
        logic [M-1:0] one;
        one = 1;
        return (i >= 0) ? (one << i) : '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_stored = -1; m_resume = -1;
            m_hold_age = 0; m_holding = 1'b0; m_wake = 1'b0;
        end else begin
            m_resume = -1;
            if (m_owner >= 0) begin
                if (done[m_owner] || !req[m_owner]) begin
                    m_owner   = -1;
                    m_holding = 1'b0;
                    m_wake    = (m_stored >= 0);
                end else if (m_holding) begin
                    if (ack[m_owner]) begin
                        m_stored  = m_owner;
                        m_owner   = -1;
                        m_holding = 1'b0;
                    end else if (m_hold_age == TO) begin
                        m_holding = 1'b0;
                    end else begin
                        m_hold_age++;
                    end
                end else if (m_stored < 0 && first_req(req) >= 0 && first_req(req) < m_owner) begin
                    m_holding  = 1'b1;
                    m_hold_age = 1;
                end
            end else if (m_wake) begin
                m_wake = 1'b0;
                if (req[m_stored]) begin
                    m_owner  = m_stored;
                    m_resume = m_stored;
                end
                m_stored = -1;
            end else if (m_stored >= 0 && (first_req(req) < 0 || first_req(req) == m_stored)) begin
                m_wake = 1'b1;
            end else begin
                m_owner = first_req(req);
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            vectors++;
            if (grant !== bit_of(m_owner)) begin
                miscompares++;
                $display("FAIL cyc_grant t=%0t got %b want %b", $time, grant, bit_of(m_owner));
            end
            if (hold !== bit_of(m_holding ? m_owner : -1)) begin
                miscompares++;
                $display("FAIL cyc_hold t=%0t got %b want %b", $time, hold, bit_of(m_holding ? m_owner : -1));
            end
            if (resume !== bit_of(m_resume)) begin
                miscompares++;
                $display("FAIL cyc_resume t=%0t got %b want %b", $time, resume, bit_of(m_resume));
            end
            if (busy !== (m_owner >= 0)) begin
                miscompares++;
                $display("FAIL cyc_busy t=%0t got %b want %b", $time, busy, (m_owner >= 0));
            end
            if (m_owner >= 0 && owner_id !== 2'(m_owner)) begin
                miscompares++;
                $display("FAIL cyc_owner t=%0t got %0d want %0d", $time, owner_id, m_owner);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [M-1:0] r, input logic [M-1:0] d, input logic [M-1:0] a);
        req  = r;
        done = d;
        ack  = a;
        @(posedge clk);
        #1;
    endtask

    // Literal expectation on the DUT; the model grant is pinned to the same literal.
    task automatic pin(input string nm, input logic [M-1:0] g, input logic [M-1:0] h, input logic [M-1:0] r);
        vectors++;
        if (grant !== g || hold !== h || resume !== r || bit_of(m_owner) !== g) begin
            miscompares++;
            $display("FAIL %s: grant/hold/resume got %b/%b/%b (model grant %b) want %b/%b/%b",
                     nm, grant, hold, resume, bit_of(m_owner), g, h, r);
        end
    endtask

    task automatic chk_owner(input string nm, input logic b, input logic [1:0] id);
        vectors++;
        if (busy !== b || owner_id !== id) begin
            miscompares++;
            $display("FAIL %s: busy/ownerId got %b/%0d want %b/%0d", nm, busy, owner_id, b, id);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 cmp_en = 1'b1;
        step(3'b000, 3'b000, 3'b000);
        pin("reset", 3'b000, 3'b000, 3'b000);
        chk_owner("reset_owner", 1'b0, 2'd0);
        step(3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        step(3'b000, 3'b000, 3'b000);
        pin("idle", 3'b000, 3'b000, 3'b000);

        // 1: plain grant and hand-over with one free cycle
        step(3'b110, 3'b000, 3'b000); pin("s1_grant", 3'b010, 3'b000, 3'b000);
        chk_owner("s1_owner1", 1'b1, 2'd1);
        step(3'b100, 3'b010, 3'b000); pin("s1_gap", 3'b000, 3'b000, 3'b000);
        step(3'b100, 3'b000, 3'b000); pin("s1_next", 3'b100, 3'b000, 3'b000);
        chk_owner("s1_owner2", 1'b1, 2'd2);
        step(3'b000, 3'b000, 3'b000); pin("s1_free", 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        // 2: preemption of 2 by 0, then resume of 2
        step(3'b100, 3'b000, 3'b000); pin("s2_own2", 3'b100, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s2_hold", 3'b100, 3'b100, 3'b000);
        repeat (4) step(3'b101, 3'b000, 3'b000);
        pin("s2_still", 3'b100, 3'b100, 3'b000);
        step(3'b101, 3'b000, 3'b100); pin("s2_ack", 3'b000, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s2_pre", 3'b001, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000);
        step(3'b100, 3'b001, 3'b000); pin("s2_rel", 3'b000, 3'b000, 3'b000);
        step(3'b100, 3'b000, 3'b000); pin("s2_resume", 3'b100, 3'b000, 3'b100);
        step(3'b100, 3'b000, 3'b000); pin("s2_after", 3'b100, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000); pin("s2_free", 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        // 3: hold timeout and retry
        step(3'b100, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s3_hold", 3'b100, 3'b100, 3'b000);
        repeat (7) step(3'b101, 3'b000, 3'b000);
        pin("s3_late", 3'b100, 3'b100, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s3_timeout", 3'b100, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s3_retry", 3'b100, 3'b100, 3'b000);
        step(3'b000, 3'b000, 3'b000); pin("s3_end", 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        // 4: 1 parked by 0, then resumed
        step(3'b010, 3'b000, 3'b000); pin("s4_own1", 3'b010, 3'b000, 3'b000);
        step(3'b011, 3'b000, 3'b000); pin("s4_hold", 3'b010, 3'b010, 3'b000);
        step(3'b011, 3'b000, 3'b010); pin("s4_ack", 3'b000, 3'b000, 3'b000);
        step(3'b011, 3'b000, 3'b000); pin("s4_pre", 3'b001, 3'b000, 3'b000);
        repeat (3) step(3'b011, 3'b000, 3'b000);
        pin("s4_nohold", 3'b001, 3'b000, 3'b000);
        step(3'b010, 3'b001, 3'b000); pin("s4_rel", 3'b000, 3'b000, 3'b000);
        step(3'b010, 3'b000, 3'b000); pin("s4_resume", 3'b010, 3'b000, 3'b010);
        step(3'b000, 3'b000, 3'b000); pin("s4_free", 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        // 4b: depth one -- with 2 parked, owner 1 is not preempted by 0
        step(3'b100, 3'b000, 3'b000);
        step(3'b110, 3'b000, 3'b000); pin("s4b_hold", 3'b100, 3'b100, 3'b000);
        step(3'b110, 3'b000, 3'b100); pin("s4b_ack", 3'b000, 3'b000, 3'b000);
        step(3'b110, 3'b000, 3'b000); pin("s4b_own1", 3'b010, 3'b000, 3'b000);
        step(3'b111, 3'b000, 3'b000);
        step(3'b111, 3'b000, 3'b000); pin("s4b_depth", 3'b010, 3'b000, 3'b000);
        step(3'b101, 3'b010, 3'b000); pin("s4b_rel", 3'b000, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s4b_resume", 3'b100, 3'b000, 3'b100);
        step(3'b101, 3'b000, 3'b000); pin("s4b_repreempt", 3'b100, 3'b100, 3'b000);
        step(3'b000, 3'b000, 3'b000); pin("s4b_free", 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        // 5: done and holdAck together -> plain release, nothing parked
        step(3'b100, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s5_hold", 3'b100, 3'b100, 3'b000);
        step(3'b101, 3'b100, 3'b100); pin("s5_both", 3'b000, 3'b000, 3'b000);
        step(3'b001, 3'b000, 3'b000); pin("s5_own0", 3'b001, 3'b000, 3'b000);
        step(3'b000, 3'b001, 3'b000); pin("s5_rel", 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000); pin("s5_noresume", 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000); pin("s5_noresume2", 3'b000, 3'b000, 3'b000);

        // 6: asynchronous reset in the middle of a hold
        step(3'b100, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000); pin("s6_hold", 3'b100, 3'b100, 3'b000);
        #2 rst_n = 1'b0;
        #1 pin("s6_async", 3'b000, 3'b000, 3'b000);
        chk_owner("s6_busy", 1'b0, 2'd0);
        step(3'b101, 3'b000, 3'b000); pin("s6_inreset", 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        step(3'b101, 3'b000, 3'b000); pin("s6_restart", 3'b001, 3'b000, 3'b000);
        chk_owner("s6_owner", 1'b1, 2'd0);
        step(3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000); pin("s6_free", 3'b000, 3'b000, 3'b000);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
